// File: rtl/kgp_mult_pkg.sv
// Shared definitions for the KGP-RISC multiply sequencer: FSM states, default width and counter width.
package kgp_mult_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      CORR = 2'd2
   } state_t;

endpackage

// File: rtl/mult_unsigned_fix.sv
// Converts the upper half of a signed product into the upper half of the unsigned product of the same bits.
module mult_unsigned_fix
   import kgp_mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] prod_hi,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_unsigned,
   output logic [WIDTH-1:0] hi
);

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;

   // A set sign bit weighs -2^(W-1) signed but +2^(W-1) unsigned; the difference lands in hi as the other operand.
   always_comb begin
      add_a = {WIDTH{1'b0}};
      add_b = {WIDTH{1'b0}};
      if (is_unsigned && a[WIDTH-1]) begin
         add_a = b;
      end else begin
         add_a = {WIDTH{1'b0}};
      end
      if (is_unsigned && b[WIDTH-1]) begin
         add_b = a;
      end else begin
         add_b = {WIDTH{1'b0}};
      end
      hi = prod_hi + add_a + add_b;
   end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle controller around the shared signed multiplier: holds operands, captures the product, fixes up unsigned results.
module mult_sequencer
   import kgp_mult_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int MULT_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   input  logic               req_unsigned,
   input  logic               flush,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic [WIDTH-1:0]   mult_a,
   output logic [WIDTH-1:0]   mult_b,
   input  logic [2*WIDTH-1:0] mult_product
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic                 is_unsigned;
   logic [2*WIDTH-1:0]   prod_q;
   logic [WIDTH-1:0]     hi_fixed;

   assign busy      = (state != IDLE);
   assign req_ready = (state == IDLE);

   mult_unsigned_fix #(.WIDTH(WIDTH)) u_fix (
      .prod_hi     (prod_q[2*WIDTH-1:WIDTH]),
      .a           (mult_a),
      .b           (mult_b),
      .is_unsigned (is_unsigned),
      .hi          (hi_fixed)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; flush wins over every other transition.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid && !flush) begin
               state_next = WAIT;
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (flush) begin
               state_next = IDLE;
            end else if (cnt == {CNT_W{1'b0}}) begin
               state_next = CORR;
            end else begin
               state_next = WAIT;
            end
         end
         CORR:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand latch, cycle counter, product capture and hi/lo write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= {CNT_W{1'b0}};
         is_unsigned <= 1'b0;
         mult_a      <= {WIDTH{1'b0}};
         mult_b      <= {WIDTH{1'b0}};
         prod_q      <= {(2*WIDTH){1'b0}};
         hi          <= {WIDTH{1'b0}};
         lo          <= {WIDTH{1'b0}};
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  mult_a      <= req_a;
                  mult_b      <= req_b;
                  is_unsigned <= req_unsigned;
                  cnt         <= CNT_LOAD;
               end else begin
                  cnt <= cnt;
               end
            end
            WAIT: begin
               if (flush) begin
                  cnt <= cnt;
               end else if (cnt != {CNT_W{1'b0}}) begin
                  cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  prod_q <= mult_product;
               end
            end
            CORR: begin
               if (!flush) begin
                  hi   <= hi_fixed;
                  lo   <= prod_q[WIDTH-1:0];
                  done <= 1'b1;
               end else begin
                  done <= 1'b0;
               end
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: a reference model queues expected products at accept, a monitor checks every cycle.
module tb_mult_sequencer;

   localparam int W  = 32;
   localparam int MC = 3;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
   } ent_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [W-1:0]   req_a = '0;
   logic [W-1:0]   req_b = '0;
   logic           req_unsigned = 1'b0;
   logic           flush = 1'b0;
   logic           busy;
   logic           done;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;
   logic [W-1:0]   mult_a;
   logic [W-1:0]   mult_b;
   logic [2*W-1:0] mult_product;

   int             n_cmp = 0;
   int             n_bad = 0;
   int             cyc = 0;
   int             n_acc = 0;
   ent_t           q[$];
   logic [W-1:0]   exp_hi = '0;
   logic [W-1:0]   exp_lo = '0;

   // Stand-in for the external signed_multiplier.
   assign mult_product = $signed(mult_a) * $signed(mult_b);

   mult_sequencer #(.WIDTH(W), .MULT_CYCLES(MC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_unsigned(req_unsigned), .flush(flush),
      .busy(busy), .done(done), .hi(hi), .lo(lo),
      .mult_a(mult_a), .mult_b(mult_b), .mult_product(mult_product)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic u);
      longint sa;
      longint sb;
      logic [2*W-1:0] ua;
      logic [2*W-1:0] ub;
      if (u) begin
         ua = {32'd0, a};
         ub = {32'd0, b};
         return ua * ub;
      end
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sa * sb;
   endfunction

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: decides acceptance and aborts from the protocol rules alone.
   initial forever begin
      ent_t e;
      logic [2*W-1:0] p;
      @(posedge clk);
      cyc++;
      if (!rst) begin
         if (flush) begin
            if (q.size() != 0) void'(q.pop_front());
         end else if (req_valid && q.size() == 0) begin
            p     = ref_prod(req_a, req_b, req_unsigned);
            e.a   = req_a;
            e.b   = req_b;
            e.hi  = p[2*W-1:W];
            e.lo  = p[W-1:0];
            e.cyc = cyc;
            q.push_back(e);
            n_acc++;
         end
      end
   end

   // Monitor: compares outputs on the falling edge, popping the scoreboard on each done pulse.
   initial forever begin
      ent_t e;
      @(negedge clk);
      if (!rst) begin
         if (done) begin
            if (q.size() == 0) begin
               check("spurious_done", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("hi", {32'd0, hi}, {32'd0, e.hi});
               check("lo", {32'd0, lo}, {32'd0, e.lo});
               check("latency", 64'(cyc - e.cyc), 64'(MC + 1));
               exp_hi = e.hi;
               exp_lo = e.lo;
            end
         end else begin
            check("hilo_hold", {hi, lo}, {exp_hi, exp_lo});
         end
         check("busy", {63'd0, busy}, {63'd0, q.size() != 0});
         check("req_ready", {63'd0, req_ready}, {63'd0, q.size() == 0});
         if (q.size() != 0) check("mult_ops", {mult_a, mult_b}, {q[0].a, q[0].b});
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (q.size() != 0 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (q.size() != 0) check("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
      wait_idle();
      req_a        = a;
      req_b        = b;
      req_unsigned = u;
      req_valid    = 1'b1;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
   endtask

   task automatic do_reset_check(input string tag);
      rst = 1'b1;
      q.delete();
      exp_hi = '0;
      exp_lo = '0;
      #1;
      check({tag, "_hilo"}, {hi, lo}, 64'd0);
      check({tag, "_done_busy"}, {62'd0, done, busy}, 64'd0);
      check({tag, "_mult_ab"}, {mult_a, mult_b}, 64'd0);
      check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] corners[6];
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           k;
      int           start;
      corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFB};

      do_reset_check("reset");
      @(posedge clk);
      #1;

      // Test-plan products with literal expectations.
      issue(32'hFFFFFFFB, 32'h4, 1'b0);
      wait_idle();
      check("tp_s_m5x4", {hi, lo}, 64'hFFFFFFFF_FFFFFFEC);
      issue(32'hFFFFFFFB, 32'h4, 1'b1);
      wait_idle();
      check("tp_u_m5x4", {hi, lo}, 64'h00000003_FFFFFFEC);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      wait_idle();
      check("tp_u_max", {hi, lo}, 64'hFFFFFFFE_00000001);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      wait_idle();
      check("tp_s_m1", {hi, lo}, 64'h00000000_00000001);

      // Back-to-back with req_valid held high.
      start = n_acc;
      req_a = 32'd7; req_b = 32'd6; req_unsigned = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_a = 32'hFFFFFFFD; req_b = 32'hFFFFFFFD;
      k = 0;
      while (n_acc < start + 2 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      req_valid = 1'b0;
      check("b2b_accepts", 64'(n_acc - start), 64'd2);
      wait_idle();
      check("tp_b2b_second", {hi, lo}, 64'h00000000_00000009);

      // Abort in the second WAIT cycle keeps the preloaded result.
      issue(32'd7, 32'd6, 1'b0);
      wait_idle();
      issue(32'd2, 32'd3, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("abort_ready", {63'd0, req_ready}, 64'd1);
      repeat (MC + 2) @(posedge clk);
      #1;
      check("abort_hilo", {hi, lo}, 64'h00000000_0000002A);

      // Flush in IDLE blocks acceptance.
      req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1; flush = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      req_valid = 1'b0; flush = 1'b0;
      check("idle_flush_busy", {63'd0, busy}, 64'd0);

      // Asynchronous reset mid-WAIT and with CORR pending.
      issue(32'h12345678, 32'h9ABCDEF0, 1'b1);
      @(posedge clk);
      #2;
      do_reset_check("rst_wait");
      issue(32'h0000FFFF, 32'h00010001, 1'b0);
      repeat (MC) @(posedge clk);
      #2;
      do_reset_check("rst_corr");
      issue(32'd11, 32'd13, 1'b0);
      wait_idle();
      check("post_reset_op", {hi, lo}, 64'd143);

      // Randomized traffic with occasional aborts.
      for (int i = 0; i < 80; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
         issue(ra, rb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 6) == 0) begin
            repeat ($urandom_range(0, MC)) @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
         end
      end
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle controller that sequences the shared combinational `signed_multiplier` for the KGP-RISC multiply instructions. It accepts one operand pair per handshake, holds the multiplier inputs stable across a multicycle path, and applies an unsigned correction when required. It then writes the 64-bit result into architectural `hi`/`lo` registers and pulses `done`. It sits between the decode/execute stage and the `signed_multiplier` instance, which is instantiated alongside it at the next level up.

## Interface
- `WIDTH`, 32: operand width; the product is 2*WIDTH.
- `MULT_CYCLES`, 3: number of cycles the multiplier inputs are held before the product is captured. Legal range is 1..15.

- `clk`  in  1: clock; every state element updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  1: a multiply request is presented.
- `req_ready`  out  1: the sequencer can accept a request this cycle.
- `req_a`  in  WIDTH: operand a.
- `req_b`  in  WIDTH: operand b.
- `req_unsigned`  in  1: 1 selects an unsigned multiply (multu); 0 selects a signed multiply (mult).
- `flush`  in  1: abort any in-flight operation.
- `busy`  out  1: an operation is in flight.
- `done`  out  1: one-cycle pulse; `hi`/`lo` have just been updated.
- `hi`  out  WIDTH: upper half of the last completed product.
- `lo`  out  WIDTH: lower half of the last completed product.
- `mult_a`  out  WIDTH: registered operand driven to `signed_multiplier.a`.
- `mult_b`  out  WIDTH: registered operand driven to `signed_multiplier.b`.
- `mult_product`  in  2*WIDTH: product from `signed_multiplier.product`.

## Operation
- States: IDLE, WAIT, CORR.
- IDLE:
  - `req_ready`=1.
  - Accept occurs when `req_valid`=1 and `flush`=0. On accept: latch `req_a`/`req_b` into `mult_a`/`mult_b`, latch `req_unsigned`, load `cnt`=MULT_CYCLES-1, go to WAIT.
- WAIT:
  - `mult_a`/`mult_b` are held constant.
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0: capture `mult_product` into `prod_q` and go to CORR.
- CORR:
  - Signed: {hi,lo} ← `prod_q`.
  - Unsigned: lo ← `prod_q[WIDTH-1:0]`; hi ← `prod_q[2W-1:W]` + (a[W-1] ? b : 0) + (b[W-1] ? a : 0), all mod 2^WIDTH.
  - Set `done`=1 and go to IDLE.
- `busy` = (state ≠ IDLE). `req_ready` = (state = IDLE). Both are combinational from state.
- `done` is a register. It is 1 only in the cycle after the CORR edge and is cleared on the next edge.
- `flush` in WAIT or CORR:
  - Go to IDLE.
  - No `hi`/`lo` write, no `done`.
  - `mult_a`/`mult_b` keep their values.
- `flush` in IDLE blocks acceptance even when `req_valid`=1.
- Back-to-back requests: a request may be accepted in the same cycle that `done`=1, since the state is IDLE.
- `hi`/`lo` change only on a CORR edge and otherwise hold their last value.
- Reset values:
  - state=IDLE, `cnt`=0.
  - `mult_a`=`mult_b`=0, `prod_q`=0.
  - `hi`=`lo`=0, `done`=0.
  - Hence `busy`=0 and `req_ready`=1 out of reset.
- Reset mid-operation returns all of the above to their reset values immediately, with no `done`.

## Timing
- Accept edge E0 → WAIT occupies edges E1..E(MULT_CYCLES). Product capture happens at E(MULT_CYCLES).
- The CORR edge is E(MULT_CYCLES+1): `hi`/`lo` update and `done`=1 in the following cycle.
- Request-to-result latency is MULT_CYCLES+1 cycles. Throughput is one operation per MULT_CYCLES+1 cycles.
- The `mult_a`/`mult_b` → `mult_product` path is a multicycle path of MULT_CYCLES cycles. `prod_q` → `hi` is single-cycle (one WIDTH-bit 3-input add).

## Structure
- Shared package `kgp_mult_pkg`:
  - state enum {IDLE, WAIT, CORR}
  - `WIDTH` default
  - the `cnt` width constant (4 bits)
- Sub-module `mult_unsigned_fix`: purely combinational.
  - Inputs: `prod_hi`, `a`, `b`, `is_unsigned`.
  - Output: corrected `hi`.
  - Reusable by any later multiply-accumulate path.
- The `signed_multiplier` instance stays outside this block.

## Test plan
- Signed, MULT_CYCLES=3: a=0xFFFFFFFB (-5), b=0x00000004 → `done` 4 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFEC, `busy` high for exactly 4 cycles.
- Unsigned: a=0xFFFFFFFB, b=0x00000004 → hi=0x00000003, lo=0xFFFFFFEC.
- Unsigned: a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Signed with the same operands → hi=0x00000000, lo=0x00000001.
- Back-to-back: with `req_valid` held, 7×6 then -3×-3 (signed) → two `done` pulses MULT_CYCLES+1 cycles apart, hi/lo=0/0x2A then 0/0x9, `req_ready` high only in the `done` cycles.
- Abort:
  - Preload hi/lo to 0/0x2A, then accept 2×3 and assert `flush` in the second WAIT cycle → no `done`, hi/lo stay 0/0x2A, `req_ready`=1 next cycle.
  - `flush`=1 with `req_valid`=1 in IDLE → not accepted.
- Reset: assert `rst` mid-WAIT and during CORR → asynchronously hi=lo=0, `done`=0, `busy`=0, `mult_a`=`mult_b`=0. A subsequent request completes normally.
